// File: rtl/add_sub_pkg.sv
// add_sub_pkg: FSM states, default operand width and derived widths for the add/sub BIST.
package add_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int W_DEF = 4;
  localparam int VEC_W = 2*W_DEF+1;
  localparam int CNT_W = 2*W_DEF+2;
  function automatic int vec_w(input int w);
    return 2*w+1;
  endfunction
  function automatic int cnt_w(input int w);
    return 2*w+2;
  endfunction
endpackage

// File: rtl/add_sub_golden.sv
// add_sub_golden: combinational reference add/sub producing the expected {cout,s}.
module add_sub_golden import add_sub_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ctrl,
  output logic [W-1:0] exp_s,
  output logic         exp_cout
);
  // Subtract is a + ~b + 1, so cout=1 means no borrow.
  always_comb {exp_cout, exp_s} = {1'b0, a} + {1'b0, b ^ {W{ctrl}}} + {{W{1'b0}}, ctrl};
endmodule

// File: rtl/add_sub_bist.sv
// add_sub_bist: exhaustive {ctrl,a,b} sweep of an external add/sub unit against a golden model.
module add_sub_bist import add_sub_pkg::*; #(
  parameter int W            = W_DEF,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  output logic           ctrl,
  input  logic [W-1:0]   s,
  input  logic           cout,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W+1:0] err_count,
  output logic [2*W:0]   first_fail
);
  localparam int VW = vec_w(W);
  localparam int CW = cnt_w(W);
  state_t r_state, w_next;
  logic [VW-1:0] r_idx;
  logic [W-1:0] w_exp_s;
  logic w_exp_cout, w_miss, w_last, w_start, w_stop;
  add_sub_golden #(.W(W)) u_golden (
    .a(a),
    .b(b),
    .ctrl(ctrl),
    .exp_s(w_exp_s),
    .exp_cout(w_exp_cout)
  );
  assign w_miss = {cout, s} != {w_exp_cout, w_exp_s};
  assign w_last = &{ctrl, a, b};
  assign busy   = r_state == RUN;
  assign done   = r_state == DONE;
  always_comb begin
    w_start = start && r_state != RUN;
    w_stop  = r_state == RUN && (w_last || (STOP_ON_FAIL && w_miss));
    w_next  = w_start ? RUN : w_stop ? DONE : r_state;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // The vector driven now is checked on the next edge, where the following one is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      {ctrl, a, b} <= '0;
      r_idx        <= '0;
      err_count    <= '0;
      first_fail   <= '0;
      pass         <= 1'b0;
    end else if (w_start) begin
      {ctrl, a, b} <= '0;
      r_idx        <= VW'(1);
      err_count    <= '0;
      first_fail   <= '0;
      pass         <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_miss && err_count != '1) err_count <= err_count + CW'(1);
      if (w_miss && err_count == '0) first_fail <= {ctrl, a, b};
      if (w_stop) pass <= err_count == '0 && !w_miss;
      else begin
        {ctrl, a, b} <= r_idx;
        r_idx        <= r_idx + VW'(1);
      end
    end
  end
endmodule

// File: tb/tb_add_sub_bist.sv
// tb_add_sub_bist: fault-injected add/sub unit swept by two BIST instances (run-through and stop-on-fail).
module tb_add_sub_bist;
  localparam int W = 4;
  typedef struct {
    int mode;
    int fidx;
    int fbit;
    int exp_err;
    int exp_first;
    bit exp_pass;
  } vec_t;
  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] a0, b0, s0, a1, b1, s1;
  logic ctrl0, cout0, busy0, done0, pass0, ctrl1, cout1, busy1, done1, pass1;
  logic [2*W+1:0] err0, err1;
  logic [2*W:0] ff0, ff1;
  int mode, fidx, fbit;
  int nvec = 0;
  int nfail = 0;
  always #5 clk = ~clk;
  function automatic logic [W:0] ref_res(input logic [2*W:0] v);
    int x, y;
    x = int'(v[2*W-1:W]);
    y = int'(v[W-1:0]);
    if (!v[2*W]) return {x + y >= 16, 4'((x + y) % 16)};
    return {x >= y, 4'((x - y + 16) % 16)};
  endfunction
  // mode 0 good, 1 cout stuck-0, 2 s[0] stuck-0, 3 flip bit fb at vector fi, 4 bit fb stuck-1
  function automatic logic [W:0] uut_res(input int m, fi, fb, input logic [2*W:0] v);
    logic [W:0] r;
    r = ref_res(v);
    if (m == 1) r[W] = 1'b0;
    if (m == 2) r[0] = 1'b0;
    if (m == 3 && int'(v) == fi) r[fb] = ~r[fb];
    if (m == 4) r[fb] = 1'b1;
    return r;
  endfunction
  always_comb {cout0, s0} = uut_res(mode, fidx, fbit, {ctrl0, a0, b0});
  always_comb {cout1, s1} = uut_res(mode, fidx, fbit, {ctrl1, a1, b1});
  add_sub_bist #(.W(W), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a(a0), .b(b0), .ctrl(ctrl0), .s(s0), .cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
  );
  add_sub_bist #(.W(W), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a1), .b(b1), .ctrl(ctrl1), .s(s1), .cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
    end
  endtask
  task automatic model(input int m, fi, fb, output int e, output int f);
    e = 0;
    f = 0;
    for (int v = 0; v < 512; v++)
      if (uut_res(m, fi, fb, 9'(v)) != ref_res(9'(v))) begin
        if (e == 0) f = v;
        e++;
      end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_0"}, {a0, b0, ctrl0, busy0, done0, pass0, err0, ff0}, 0);
    chk({nm, "_1"}, {a1, b1, ctrl1, busy1, done1, pass1, err1, ff1}, 0);
  endtask
  // Start both DUTs, optionally pulse start or rst at a given post-start cycle, record DONE latency.
  task automatic sweep(input int start_at, input int rst_at, output int lat0, output int lat1, output int bc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cleared0", {err0, ff0, pass0, busy0}, 21'd1);
    chk("cleared1", {err1, ff1, pass1, busy1}, 21'd1);
    lat0 = 0;
    lat1 = 0;
    bc = int'(busy0);
    for (int c = 1; c <= 600 && (lat0 == 0 || lat1 == 0); c++) begin
      start = c == start_at;
      rst = c == rst_at;
      @(posedge clk); #1;
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        break;
      end
      bc += int'(busy0);
      if (done0 && lat0 == 0) lat0 = c;
      if (done1 && lat1 == 0) lat1 = c;
    end
  endtask
  initial begin
    vec_t tbl[8];
    int l0, l1, bc;
    tbl[0] = '{0, 0, 0, 0, 0, 1'b1};
    tbl[1] = '{1, 0, 0, 256, 'h01F, 1'b0};
    tbl[2] = '{2, 0, 0, 256, 'h001, 1'b0};
    tbl[3] = '{3, 511, 4, 1, 511, 1'b0};
    for (int i = 4; i < 8; i++) begin
      tbl[i].mode = 3 + i % 2;
      tbl[i].fidx = int'($urandom_range(0, 511));
      tbl[i].fbit = int'($urandom_range(0, 4));
      model(tbl[i].mode, tbl[i].fidx, tbl[i].fbit, tbl[i].exp_err, tbl[i].exp_first);
      tbl[i].exp_pass = tbl[i].exp_err == 0;
    end
    rst = 1'b1;
    start = 1'b1;
    mode = 0;
    fidx = 0;
    fbit = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_hold", {busy0, done0, busy1, done1}, 0);
    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      fidx = tbl[i].fidx;
      fbit = tbl[i].fbit;
      sweep(i == 0 ? 50 : -1, -1, l0, l1, bc);
      chk($sformatf("lat0[%0d]", i), l0, 512);
      chk($sformatf("busy_cycles[%0d]", i), bc, 512);
      chk($sformatf("err0[%0d]", i), err0, tbl[i].exp_err);
      chk($sformatf("first0[%0d]", i), ff0, tbl[i].exp_err > 0 ? tbl[i].exp_first : 0);
      chk($sformatf("pass0[%0d]", i), {done0, busy0, pass0}, {2'b10, tbl[i].exp_pass});
      chk($sformatf("hold0[%0d]", i), {ctrl0, a0, b0}, 511);
      chk($sformatf("lat1[%0d]", i), l1, tbl[i].exp_err > 0 ? tbl[i].exp_first + 1 : 512);
      chk($sformatf("err1[%0d]", i), err1, tbl[i].exp_err > 0 ? 1 : 0);
      chk($sformatf("first1[%0d]", i), ff1, tbl[i].exp_err > 0 ? tbl[i].exp_first : 0);
      chk($sformatf("pass1[%0d]", i), {done1, pass1}, {1'b1, tbl[i].exp_pass});
      chk($sformatf("hold1[%0d]", i), {ctrl1, a1, b1}, tbl[i].exp_err > 0 ? tbl[i].exp_first : 511);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("done_hold[%0d]", i), {done0, err0, done1, err1}, {1'b1, 10'(tbl[i].exp_err), 1'b1, 10'(tbl[i].exp_err > 0)});
    end
    mode = 0;
    sweep(-1, 100, l0, l1, bc);
    chk_zero("midrun_reset");
    @(posedge clk); #1;
    chk("post_reset_idle", {busy0, done0, busy1, done1}, 0);
    sweep(-1, -1, l0, l1, bc);
    chk("resweep_lat", {l0[15:0], l1[15:0], bc[15:0]}, {16'd512, 16'd512, 16'd512});
    chk("resweep_pass", {pass0, err0, pass1, err1}, {1'b1, 10'd0, 1'b1, 10'd0});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
